dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arbiter_if.sv | 30 +++
 rtl/dmem_arbiter_rr_arb2.sv | 51 +++++
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  // Default memory byte-address width (32-byte data memory).
  localparam int unsigned ADDR_W_DEF = 5;

  // Transaction FSM: one transaction in flight, three cycles each.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Requester id to its one-hot ack position.
  function automatic logic [1:0] id_to_onehot(input logic id);
    logic [1:0] oh;
    if (id) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
interface dmem_arbiter_if;

  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [31:0] addr0_i;
  logic [31:0] wdata0_i;
  logic [31:0] addr1_i;
  logic [31:0] wdata1_i;
  logic [1:0]  ack_o;
  logic [31:0] rdata_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_wr_o;
  logic        mem_rd_o;
  logic [31:0] mem_rdata_i;

  // Arbiter side.
  modport slave (
    input  req_i, we_i, addr0_i, wdata0_i, addr1_i, wdata1_i, mem_rdata_i,
    output ack_o, rdata_o, mem_addr_o, mem_wdata_o, mem_wr_o, mem_rd_o
  );

  // Requester / memory side.
  modport master (
    output req_i, we_i, addr0_i, wdata0_i, addr1_i, wdata1_i, mem_rdata_i,
    input  ack_o, rdata_o, mem_addr_o, mem_wdata_o, mem_wr_o, mem_rd_o
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-served pointer.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic last_q;
  logic last_d;
  logic gnt_id_s;
  logic gnt_valid_s;

  // Pick a requester: on a tie, the one not served last; otherwise the lone one.
  always_comb begin
    gnt_id_s    = 1'b0;
    gnt_valid_s = en_i & (|req_i);
    if (req_i == 2'b11) begin
      gnt_id_s = ~last_q;
    end else if (req_i[0]) begin
      gnt_id_s = 1'b0;
    end else begin
      gnt_id_s = 1'b1;
    end
  end

  // The pointer only moves when a grant is actually issued.
  always_comb begin
    last_d = last_q;
    if (gnt_valid_s) begin
      last_d = gnt_id_s;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign gnt_valid_o = gnt_valid_s;
  assign gnt_id_o    = gnt_id_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> DONE per transaction.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input logic           clk_i,
  input logic           rst_i,
  dmem_arbiter_if.slave bus
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               id_q, id_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         ack_q, ack_d;
  logic               gnt_valid_s;
  logic               gnt_id_s;
  logic               mem_wr_s;
  logic               mem_rd_s;
  logic               unused_addr_hi_s;

  // Address bits above the memory width are deliberately discarded.
  assign unused_addr_hi_s = ^{bus.addr0_i[31:ADDR_W], bus.addr1_i[31:ADDR_W]};

  rr_arb2 u_rr_arb2 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (bus.req_i),
    .en_i        (state_q == ST_IDLE),
    .gnt_valid_o (gnt_valid_s),
    .gnt_id_o    (gnt_id_s)
  );

  // Next-state, request latching, read capture and ack generation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    id_d    = id_q;
    rdata_d = rdata_q;
    ack_d   = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_d = ST_ACCESS;
          id_d    = gnt_id_s;
          if (gnt_id_s) begin
            addr_d  = bus.addr1_i[ADDR_W-1:0];
            wdata_d = bus.wdata1_i;
            we_d    = bus.we_i[1];
          end else begin
            addr_d  = bus.addr0_i[ADDR_W-1:0];
            wdata_d = bus.wdata0_i;
            we_d    = bus.we_i[0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        ack_d   = id_to_onehot(id_q);
        if (!we_q) begin
          rdata_d = bus.mem_rdata_i;
        end else begin
          rdata_d = rdata_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes only in ACCESS, and killed by reset so an in-flight write aborts.
  always_comb begin
    mem_wr_s = 1'b0;
    mem_rd_s = 1'b0;
    if ((state_q == ST_ACCESS) && !rst_i) begin
      mem_wr_s = we_q;
      mem_rd_s = ~we_q;
    end else begin
      mem_wr_s = 1'b0;
      mem_rd_s = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      we_q    <= 1'b0;
      id_q    <= 1'b0;
      rdata_q <= 32'h0000_0000;
      ack_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  // The latched address/data double as the memory bus, so they hold between accesses.
  assign bus.mem_addr_o  = {{(32 - ADDR_W){1'b0}}, addr_q};
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_wr_o    = mem_wr_s;
  assign bus.mem_rd_o    = mem_rd_s;
  assign bus.ack_o       = ack_q;
  assign bus.rdata_o     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 32-byte wrapping memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   wr_pulses = 0;

  dmem_arbiter_if bus();

  dmem_arbiter #(.ADDR_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Byte-wide little-endian memory, wrapping modulo 32.
  logic [7:0] mem [0:31] = '{default: 8'h00};
  logic [4:0] a0, a1, a2, a3;

  always_comb begin
    a0 = bus.mem_addr_o[4:0];
    a1 = a0 + 5'd1;
    a2 = a0 + 5'd2;
    a3 = a0 + 5'd3;
    bus.mem_rdata_i = {mem[a3], mem[a2], mem[a1], mem[a0]};
  end

  always @(posedge clk) begin
    if (bus.mem_wr_o) begin
      mem[a0] <= bus.mem_wdata_o[7:0];
      mem[a1] <= bus.mem_wdata_o[15:8];
      mem[a2] <= bus.mem_wdata_o[23:16];
      mem[a3] <= bus.mem_wdata_o[31:24];
    end
  end

  always @(posedge clk) begin
    if (bus.mem_wr_o) wr_pulses++;
  end

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_i = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one transaction from a negedge in IDLE; return what was observed; back in IDLE at exit.
  task automatic run_txn(input logic [1:0] req, input logic [1:0] we,
                         input logic [31:0] ad0, input logic [31:0] wd0,
                         input logic [31:0] ad1, input logic [31:0] wd1,
                         output logic [1:0] ack_seen, output logic [31:0] rdata_seen,
                         output logic [31:0] maddr_seen, output logic [31:0] mwdata_seen,
                         output int wr_cyc, output int rd_cyc, output int lat);
    ack_seen = 2'b00; rdata_seen = 32'h0; maddr_seen = 32'hFFFF_FFFF; mwdata_seen = 32'h0;
    wr_cyc = 0; rd_cyc = 0; lat = 0;
    bus.req_i = req; bus.we_i = we;
    bus.addr0_i = ad0; bus.wdata0_i = wd0; bus.addr1_i = ad1; bus.wdata1_i = wd1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_wr_o) begin wr_cyc++; maddr_seen = bus.mem_addr_o; mwdata_seen = bus.mem_wdata_o; end
      if (bus.mem_rd_o) begin rd_cyc++; maddr_seen = bus.mem_addr_o; end
      if (bus.ack_o != 2'b00) begin
        ack_seen = bus.ack_o; rdata_seen = bus.rdata_o; lat = c;
        break;
      end
    end
    bus.req_i = 2'b00;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    if (bus.ack_o !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", bus.ack_o); end
    checks++;
    if (bus.rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata_o); end
    checks++;
    if (bus.mem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_maddr got=%h exp=0", bus.mem_addr_o); end
    checks++;
    if (bus.mem_wdata_o !== 32'h0) begin failures++; $display("FAIL reset_mwdata got=%h exp=0", bus.mem_wdata_o); end
    checks++;
    if ({bus.mem_wr_o, bus.mem_rd_o} !== 2'b00) begin
      failures++; $display("FAIL reset_strobes got=%b%b exp=00", bus.mem_wr_o, bus.mem_rd_o);
    end
    checks++;
  endtask

  task automatic test_write_read();
    logic [1:0] ack; logic [31:0] rd, ma, mw; int wc, rc, lat;
    run_txn(2'b01, 2'b01, 32'h4, 32'hDEAD_BEEF, 32'h0, 32'h0, ack, rd, ma, mw, wc, rc, lat);
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL wr_ack got=%b exp=01", ack); end
    checks++; if (lat != 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    checks++; if (wc != 1 || rc != 0) begin failures++; $display("FAIL wr_strobes got wr=%0d rd=%0d exp wr=1 rd=0", wc, rc); end
    checks++; if (ma !== 32'h4 || mw !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL wr_bus got addr=%h data=%h exp addr=4 data=deadbeef", ma, mw);
    end
    checks++; if (bus.mem_addr_o !== 32'h4 || bus.mem_wr_o !== 1'b0) begin
      failures++; $display("FAIL idle_hold got addr=%h wr=%b exp addr=4 wr=0", bus.mem_addr_o, bus.mem_wr_o);
    end
    run_txn(2'b10, 2'b00, 32'h0, 32'h0, 32'h4, 32'h0, ack, rd, ma, mw, wc, rc, lat);
    checks++; if (ack !== 2'b10) begin failures++; $display("FAIL rd_ack got=%b exp=10", ack); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    checks++; if (rc != 1 || wc != 0 || lat != 2) begin
      failures++; $display("FAIL rd_strobes got rd=%0d wr=%0d lat=%0d exp rd=1 wr=0 lat=2", rc, wc, lat);
    end
  endtask

  task automatic test_single_repeat();
    logic [1:0] ack; logic [31:0] rd, ma, mw; int wc, rc, lat;
    run_txn(2'b10, 2'b00, 32'h0, 32'h0, 32'h4, 32'h0, ack, rd, ma, mw, wc, rc, lat);
    checks++; if (ack !== 2'b10) begin failures++; $display("FAIL single_again_ack got=%b exp=10", ack); end
    run_txn(2'b10, 2'b10, 32'h0, 32'h0, 32'hC, 32'hA5A5_A5A5, ack, rd, ma, mw, wc, rc, lat);
    checks++; if (ack !== 2'b10 || wc != 1) begin
      failures++; $display("FAIL single_wr got ack=%b wr=%0d exp ack=10 wr=1", ack, wc);
    end
    checks++; if (bus.rdata_o !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL wr_keeps_rdata got=%h exp=deadbeef", bus.rdata_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ack; logic [31:0] exp_rd; logic [1:0] ack; int lat;
    apply_reset();
    bus.we_i = 2'b00; bus.addr0_i = 32'h4; bus.addr1_i = 32'hC;
    bus.req_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_rd  = (i % 2 == 0) ? 32'hDEAD_BEEF : 32'hA5A5_A5A5;
      ack = 2'b00; lat = 0;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.ack_o != 2'b00) begin ack = bus.ack_o; lat = c; break; end
      end
      checks++;
      if (ack !== exp_ack || lat != 2) begin
        failures++; $display("FAIL rr_grant%0d got ack=%b lat=%0d exp ack=%b lat=2", i, ack, lat, exp_ack);
      end
      checks++;
      if (bus.rdata_o !== exp_rd) begin
        failures++; $display("FAIL rr_rdata%0d got=%h exp=%h", i, bus.rdata_o, exp_rd);
      end
      if (i == 3) bus.req_i = 2'b00;
      else bus.req_i = bus.req_i & ~exp_ack;
      @(posedge clk);
      @(negedge clk);
      if (i != 3) bus.req_i = 2'b11;
    end
  endtask

  task automatic test_wrap();
    logic [1:0] ack; logic [31:0] rd, ma, mw; int wc, rc, lat;
    run_txn(2'b01, 2'b01, 32'h1E, 32'h1122_3344, 32'h0, 32'h0, ack, rd, ma, mw, wc, rc, lat);
    checks++; if (ack !== 2'b01 || ma !== 32'h1E) begin
      failures++; $display("FAIL wrap_wr got ack=%b addr=%h exp ack=01 addr=1e", ack, ma);
    end
    checks++; if ({mem[1], mem[0], mem[31], mem[30]} !== 32'h1122_3344) begin
      failures++; $display("FAIL wrap_bytes got=%h exp=11223344", {mem[1], mem[0], mem[31], mem[30]});
    end
    run_txn(2'b01, 2'b00, 32'h1E, 32'h0, 32'h0, 32'h0, ack, rd, ma, mw, wc, rc, lat);
    checks++; if (rd !== 32'h1122_3344) begin failures++; $display("FAIL wrap_rd got=%h exp=11223344", rd); end
    run_txn(2'b01, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, ack, rd, ma, mw, wc, rc, lat);
    checks++; if (rd !== 32'h0000_1122) begin failures++; $display("FAIL wrap_rd0 got=%h exp=00001122", rd); end
  endtask

  task automatic test_high_addr();
    logic [1:0] ack; logic [31:0] rd, ma, mw; int wc, rc, lat;
    run_txn(2'b10, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFE4, 32'h0, ack, rd, ma, mw, wc, rc, lat);
    checks++; if (ma !== 32'h4) begin failures++; $display("FAIL high_addr got=%h exp=00000004", ma); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL high_rd got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_abort();
    logic [1:0] ack; logic [31:0] rd, ma, mw; int wc, rc, lat, pulses, acks;
    run_txn(2'b01, 2'b01, 32'h8, 32'hCAFE_F00D, 32'h0, 32'h0, ack, rd, ma, mw, wc, rc, lat);
    pulses = wr_pulses;
    bus.req_i = 2'b01; bus.we_i = 2'b01; bus.addr0_i = 32'h8; bus.wdata0_i = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.mem_wr_o !== 1'b1) begin failures++; $display("FAIL abort_in_access got wr=%b exp=1", bus.mem_wr_o); end
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_wr_o !== 1'b0) begin failures++; $display("FAIL abort_forced got wr=%b exp=0", bus.mem_wr_o); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_i = 2'b00;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.ack_o != 2'b00) acks++;
      @(negedge clk);
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL abort_ack got=%0d exp=0", acks); end
    checks++; if (wr_pulses != pulses) begin
      failures++; $display("FAIL abort_wr_pulse got=%0d exp=%0d", wr_pulses, pulses);
    end
    checks++; if (bus.mem_addr_o !== 32'h0 || bus.rdata_o !== 32'h0) begin
      failures++; $display("FAIL abort_regs got addr=%h rdata=%h exp 0 0", bus.mem_addr_o, bus.rdata_o);
    end
    run_txn(2'b01, 2'b00, 32'h8, 32'h0, 32'h0, 32'h0, ack, rd, ma, mw, wc, rc, lat);
    checks++; if (rd !== 32'hCAFE_F00D || lat != 2 || ack !== 2'b01) begin
      failures++; $display("FAIL abort_readback got=%h lat=%0d ack=%b exp=cafef00d lat=2 ack=01", rd, lat, ack);
    end
  endtask

  initial begin
    bus.req_i = 2'b00; bus.we_i = 2'b00;
    bus.addr0_i = 32'h0; bus.wdata0_i = 32'h0; bus.addr1_i = 32'h0; bus.wdata1_i = 32'h0;
    apply_reset();
    test_reset();
    test_write_read();
    test_single_repeat();
    test_round_robin();
    test_wrap();
    test_high_addr();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
